add_result_stage: RTL and testbench

//  Registered output stage downstream of the 32-bit ripple adder (FADDER32).

---
 rtl/add_pkg.sv | 26 ++
 rtl/add_flag_gen.sv | 33 +++
 rtl/add_result_stage.sv | 154 +++++++++++++++
 tb/tb_add_result_stage.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/add_pkg.sv
// ---------------------------------------------------------------------------
// add_pkg
// Shared definitions for the adder result stage:
//   ADD_WIDTH   - datapath width of the upstream ripple adder
//   add_flags_t - status flags registered alongside each result
//   state_t     - occupancy of the two-entry skid buffer
// ---------------------------------------------------------------------------
package add_pkg;

   localparam int ADD_WIDTH = 32;

   typedef struct packed {
      logic carry;
      logic zero;
      logic neg;
      logic ovf;
   } add_flags_t;

   // EMPTY: nothing held, ONE: main register valid, FULL: main and skid valid
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

endpackage

// File: rtl/add_flag_gen.sv
// ---------------------------------------------------------------------------
// add_flag_gen
// Combinational status flags for an adder result.
// Ports:
//   sum    in  WIDTH  adder sum
//   a_msb  in  1      sign bit of operand A
//   b_msb  in  1      sign bit of operand B
//   zero   out 1      sum is all zeros
//   neg    out 1      sign bit of sum
//   ovf    out 1      signed overflow
// ---------------------------------------------------------------------------
module add_flag_gen
   import add_pkg::*;
#(
   parameter int WIDTH = ADD_WIDTH
) (
   input  logic [WIDTH-1:0] sum,
   input  logic             a_msb,
   input  logic             b_msb,
   output logic             zero,
   output logic             neg,
   output logic             ovf
);

   // Signed overflow happens only when both operands share a sign and the
   // result's sign differs from it; this also covers a carry-in of one.
   always_comb begin
      zero = ~|sum;
      neg  = sum[WIDTH-1];
      ovf  = (a_msb == b_msb) & (sum[WIDTH-1] != a_msb);
   end

endmodule

// File: rtl/add_result_stage.sv
// ---------------------------------------------------------------------------
// add_result_stage
// Registered output stage behind the 32-bit ripple adder. Captures sum, carry
// and derived flags, presents them on a valid/ready interface, and uses a
// two-entry skid buffer so in_ready is a pure register output.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid / in_ready   upstream handshake (in_ready registered)
//   in_sum, in_carry      adder result
//   in_a_msb, in_b_msb    operand sign bits for overflow detection
//   out_valid / out_ready downstream handshake
//   out_sum, out_carry,
//   out_zero, out_neg,
//   out_ovf               registered result and flags
//   acc_count             accepted-input counter, wraps modulo 2^CNT_WIDTH
// ---------------------------------------------------------------------------
module add_result_stage
   import add_pkg::*;
#(
   parameter int WIDTH     = ADD_WIDTH,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_sum,
   input  logic                 in_carry,
   input  logic                 in_a_msb,
   input  logic                 in_b_msb,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_sum,
   output logic                 out_carry,
   output logic                 out_zero,
   output logic                 out_neg,
   output logic                 out_ovf,
   output logic [CNT_WIDTH-1:0] acc_count
);

   logic             flag_zero;
   logic             flag_neg;
   logic             flag_ovf;
   add_flags_t       in_flags;

   state_t           state;
   logic [WIDTH-1:0] main_sum;
   logic [WIDTH-1:0] skid_sum;
   add_flags_t       main_flags;
   add_flags_t       skid_flags;
   logic             accept;
   logic             consume;

   add_flag_gen #(
      .WIDTH (WIDTH)
   ) u_flag_gen (
      .sum   (in_sum),
      .a_msb (in_a_msb),
      .b_msb (in_b_msb),
      .zero  (flag_zero),
      .neg   (flag_neg),
      .ovf   (flag_ovf)
   );

   // Bundle the incoming flags and decode both handshakes.
   always_comb begin
      in_flags.carry = in_carry;
      in_flags.zero  = flag_zero;
      in_flags.neg   = flag_neg;
      in_flags.ovf   = flag_ovf;
      accept         = in_valid & in_ready;
      consume        = out_valid & out_ready;
   end

   // Skid buffer state machine. The main register always feeds out_*; the
   // skid register only holds the second entry while FULL. out_valid and
   // in_ready are registered from the next state so neither depends
   // combinationally on the opposite handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= EMPTY;
         out_valid  <= 1'b0;
         in_ready   <= 1'b1;
         main_sum   <= '0;
         skid_sum   <= '0;
         main_flags <= '0;
         skid_flags <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  main_sum   <= in_sum;
                  main_flags <= in_flags;
                  state      <= ONE;
                  out_valid  <= 1'b1;
                  in_ready   <= 1'b1;
               end
            end
            ONE: begin
               if (accept && consume) begin
                  main_sum   <= in_sum;
                  main_flags <= in_flags;
                  state      <= ONE;
                  out_valid  <= 1'b1;
                  in_ready   <= 1'b1;
               end else if (accept) begin
                  skid_sum   <= in_sum;
                  skid_flags <= in_flags;
                  state      <= FULL;
                  out_valid  <= 1'b1;
                  in_ready   <= 1'b0;
               end else if (consume) begin
                  state      <= EMPTY;
                  out_valid  <= 1'b0;
                  in_ready   <= 1'b1;
               end
            end
            FULL: begin
               if (consume) begin
                  main_sum   <= skid_sum;
                  main_flags <= skid_flags;
                  state      <= ONE;
                  out_valid  <= 1'b1;
                  in_ready   <= 1'b1;
               end
            end
            default: begin
               state      <= EMPTY;
               out_valid  <= 1'b0;
               in_ready   <= 1'b1;
            end
         endcase
      end
   end

   // Accepted-result counter; natural binary wrap from all-ones to zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_count <= '0;
      end else if (accept) begin
         acc_count <= acc_count + 1'b1;
      end
   end

   // The main register is the architectural output.
   always_comb begin
      out_sum   = main_sum;
      out_carry = main_flags.carry;
      out_zero  = main_flags.zero;
      out_neg   = main_flags.neg;
      out_ovf   = main_flags.ovf;
   end

endmodule

// File: tb/tb_add_result_stage.sv
// ---------------------------------------------------------------------------
// tb_add_result_stage
// Self-checking bench for add_result_stage. Operands are added in the bench,
// the result fed to the stage, and a FIFO queue model predicts handshakes,
// output data, flags and the accept counter.
// ---------------------------------------------------------------------------
module tb_add_result_stage;

   typedef struct {
      logic [31:0] sum;
      logic        carry;
      logic        zero;
      logic        neg;
      logic        ovf;
   } entry_t;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_sum;
   logic        in_carry;
   logic        in_a_msb;
   logic        in_b_msb;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_sum;
   logic        out_carry;
   logic        out_zero;
   logic        out_neg;
   logic        out_ovf;
   logic [15:0] acc_count;

   int          checks;
   int          failures;

   entry_t      model_q[$];
   logic [15:0] model_count;

   add_result_stage #(
      .WIDTH     (32),
      .CNT_WIDTH (16)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sum    (in_sum),
      .in_carry  (in_carry),
      .in_a_msb  (in_a_msb),
      .in_b_msb  (in_b_msb),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_carry (out_carry),
      .out_zero  (out_zero),
      .out_neg   (out_neg),
      .out_ovf   (out_ovf),
      .acc_count (acc_count)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts the check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Reference result of a+b+cin using plain arithmetic; overflow decided by
   // whether the signed sum leaves the 32-bit signed range.
   function automatic entry_t refAdd(input logic [31:0] a, input logic [31:0] b,
                                     input logic cin);
      entry_t      e;
      logic [32:0] wide;
      longint      s;
      wide    = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      s       = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
      e.sum   = wide[31:0];
      e.carry = wide[32];
      e.zero  = (wide[31:0] == 32'd0);
      e.neg   = (wide[31:0] >= 32'h8000_0000);
      e.ovf   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      return e;
   endfunction

   // Compare DUT outputs with the model's view of the FIFO.
   task automatic checkState(input string tag);
      checkOutput({tag, "_in_ready"}, {63'd0, in_ready}, {63'd0, model_q.size() < 2});
      checkOutput({tag, "_out_valid"}, {63'd0, out_valid}, {63'd0, model_q.size() > 0});
      checkOutput({tag, "_acc_count"}, {48'd0, acc_count}, {48'd0, model_count});
      if (model_q.size() > 0) begin
         checkOutput({tag, "_sum"}, {32'd0, out_sum}, {32'd0, model_q[0].sum});
         checkOutput({tag, "_flags"}, {60'd0, out_carry, out_zero, out_neg, out_ovf},
                     {60'd0, model_q[0].carry, model_q[0].zero, model_q[0].neg, model_q[0].ovf});
      end
   endtask

   // One clock of stimulus: drive at negedge, update model at posedge,
   // compare at the following negedge.
   task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                                input logic cin, input logic ordy, input logic rst,
                                input string tag);
      entry_t e;
      logic   m_accept;
      logic   m_consume;
      e         = refAdd(a, b, cin);
      reset     = rst;
      in_valid  = v;
      in_sum    = e.sum;
      in_carry  = e.carry;
      in_a_msb  = a[31];
      in_b_msb  = b[31];
      out_ready = ordy;
      @(posedge clk);
      m_accept  = v && (model_q.size() < 2);
      m_consume = (model_q.size() > 0) && ordy;
      if (rst) begin
         model_q.delete();
         model_count = 16'd0;
      end else begin
         if (m_consume) void'(model_q.pop_front());
         if (m_accept) begin
            model_q.push_back(e);
            model_count = model_count + 16'd1;
         end
      end
      @(negedge clk);
      checkState(tag);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, "idle");
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      model_count = 16'd0;
      reset       = 1'b1;
      in_valid    = 1'b0;
      in_sum      = '0;
      in_carry    = 1'b0;
      in_a_msb    = 1'b0;
      in_b_msb    = 1'b0;
      out_ready   = 1'b0;

      // Reset state
      @(negedge clk);
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, "reset");
      checkOutput("reset_out_sum", {32'd0, out_sum}, 64'd0);
      checkOutput("reset_flags", {60'd0, out_carry, out_zero, out_neg, out_ovf}, 64'd0);
      checkOutput("reset_in_ready", {63'd0, in_ready}, 64'd1);

      // T1..T4 directed arithmetic cases, one cycle after accept
      applyStimulus(1'b1, 32'hF000_0000, 32'h0000_0007, 1'b0, 1'b1, 1'b0, "t1");
      checkOutput("t1_sum", {32'd0, out_sum}, 64'hF000_0007);
      checkOutput("t1_cznv", {60'd0, out_carry, out_zero, out_neg, out_ovf}, 64'b0010);
      idle(1);
      applyStimulus(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, "t2");
      checkOutput("t2_sum", {32'd0, out_sum}, 64'hFFFF_FFFE);
      checkOutput("t2_cznv", {60'd0, out_carry, out_zero, out_neg, out_ovf}, 64'b1010);
      idle(1);
      applyStimulus(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0, "t3");
      checkOutput("t3_sum", {32'd0, out_sum}, 64'h8000_0000);
      checkOutput("t3_cznv", {60'd0, out_carry, out_zero, out_neg, out_ovf}, 64'b0011);
      idle(1);
      applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0, "t4");
      checkOutput("t4_sum", {32'd0, out_sum}, 64'h0000_0000);
      checkOutput("t4_cznv", {60'd0, out_carry, out_zero, out_neg, out_ovf}, 64'b1100);
      idle(1);

      // T5 back-pressure: three offers, two accepted, output held, then drain
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, "t5_reset");
      applyStimulus(1'b1, 32'h0000_0011, 32'h0000_0022, 1'b0, 1'b0, 1'b0, "t5_a");
      applyStimulus(1'b1, 32'h0000_0100, 32'h0000_0200, 1'b1, 1'b0, 1'b0, "t5_b");
      applyStimulus(1'b1, 32'h0000_1000, 32'h0000_2000, 1'b0, 1'b0, 1'b0, "t5_c");
      checkOutput("t5_in_ready_low", {63'd0, in_ready}, 64'd0);
      checkOutput("t5_held_sum", {32'd0, out_sum}, 64'h0000_0033);
      checkOutput("t5_acc_count", {48'd0, acc_count}, 64'd2);
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, "t5_drain1");
      checkOutput("t5_second_sum", {32'd0, out_sum}, 64'h0000_0301);
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, "t5_drain2");
      checkOutput("t5_drained", {63'd0, out_valid}, 64'd0);

      // Randomized traffic with random back-pressure
      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 3) != 0), 1'b0, "rand");
      end
      for (int i = 0; i < 200; i++) begin
         applyStimulus(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 1'b0,
                       1'($urandom_range(0, 3) == 0), 1'b0, "rand_bp");
      end

      // T6 reset while FULL wins over a simultaneous accept and consume
      applyStimulus(1'b1, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0, "t6_fill1");
      applyStimulus(1'b1, 32'h3, 32'h4, 1'b0, 1'b0, 1'b0, "t6_fill2");
      applyStimulus(1'b1, 32'h5, 32'h6, 1'b0, 1'b1, 1'b1, "t6_reset");
      checkOutput("t6_out_valid", {63'd0, out_valid}, 64'd0);
      checkOutput("t6_acc_count", {48'd0, acc_count}, 64'd0);
      checkOutput("t6_in_ready", {63'd0, in_ready}, 64'd1);

      // Counter wrap: 65535 accepts reach all-ones, one more wraps to zero
      for (int i = 0; i < 65535; i++) begin
         applyStimulus(1'b1, $urandom, $urandom, 1'b0, 1'b1, 1'b0, "wrap_run");
      end
      checkOutput("wrap_all_ones", {48'd0, acc_count}, 64'hFFFF);
      applyStimulus(1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, "wrap_step");
      checkOutput("wrap_zero", {48'd0, acc_count}, 64'd0);
      checkOutput("wrap_zero_sum", {32'd0, out_sum}, 64'd0);
      checkOutput("wrap_zero_flag", {63'd0, out_zero}, 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
